// File: rtl/i2s_rx_deser.sv
// I2S slave receiver: oversamples SCK/WS/SD on the FIFO write clock and pushes
// each completed left/right word into the downstream FIFO write port.
module i2s_rx_deser #(
  parameter int data_width  = 16,
  parameter int sync_stages = 2,
  parameter int cnt_width   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_ovr,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [data_width-1:0] din,
  output logic                  ch,
  output logic                  synced,
  output logic                  overrun
);

  localparam int IW = (data_width > 1) ? $clog2(data_width) : 1;

  logic [sync_stages-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_s, ws_s, sd_s, sck_d;
  logic                   rise, ws_change, in_range, drop;
  logic                   ws_p, have_ws;
  logic [cnt_width-1:0]   bit_cnt, cnt_next;
  logic [data_width-1:0]  shreg, word_next;
  logic [IW-1:0]          bit_idx;

  // Stage 0: synchronise the asynchronous I2S pins and find SCK rising edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[sync_stages-2:0], i2s_sck};
      ws_sync  <= {ws_sync[sync_stages-2:0], i2s_ws};
      sd_sync  <= {sd_sync[sync_stages-2:0], i2s_sd};
      sck_d    <= sck_s;
    end
  end

  assign sck_s = sck_sync[sync_stages-1];
  assign ws_s  = ws_sync[sync_stages-1];
  assign sd_s  = sd_sync[sync_stages-1];
  assign rise  = sck_s & ~sck_d;

  // A WS change is only meaningful once ws_p holds a real sampled value
  assign ws_change = have_ws & (ws_s != ws_p);
  assign in_range  = int'(bit_cnt) < data_width;
  assign cnt_next  = (bit_cnt == '1) ? bit_cnt : bit_cnt + cnt_width'(1);
  assign drop      = en & rise & ws_change & synced & fifo_full;

  always_comb begin
    bit_idx   = IW'(data_width - 1 - int'(bit_cnt));
    word_next = shreg;
    if (in_range) word_next[bit_idx] = sd_s;
  end

  // Stage 1: shift, detect slot boundary, and issue the FIFO write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_p    <= 1'b0;
      have_ws <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      synced  <= 1'b0;
      wr_en   <= 1'b0;
      din     <= '0;
      ch      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      if (!en) begin
        synced  <= 1'b0;
        have_ws <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (rise) begin
        ws_p    <= ws_s;
        have_ws <= 1'b1;
        if (ws_change) begin
          shreg   <= '0;
          bit_cnt <= '0;
          // The first boundary only aligns the frame; its partial word is discarded
          if (!synced) begin
            synced <= 1'b1;
          end else if (!fifo_full) begin
            wr_en <= 1'b1;
            din   <= word_next;
            ch    <= ws_p;
          end
        end else begin
          shreg   <= word_next;
          bit_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: SCK = clk/8, bits driven on negedge of clk.
module tb_i2s_rx_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        clr_ovr = 1'b0;
  logic        i2s_sck = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_sd = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [15:0] din;
  logic        ch;
  logic        synced;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;

  logic [15:0] q_din[$];
  logic        q_ch[$];
  int          q_cyc[$];

  i2s_rx_deser dut (
    .clk(clk), .rst(rst), .en(en), .clr_ovr(clr_ovr),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .fifo_full(fifo_full), .wr_en(wr_en), .din(din), .ch(ch),
    .synced(synced), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_din.push_back(din);
      q_ch.push_back(ch);
      q_cyc.push_back(cyc);
    end
  end

  // One SCK period (8 clk). Optionally pulses clr_ovr exactly in the rise cycle.
  task automatic send_bit(input logic ws, input logic sd, input logic clr);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (4) @(negedge clk);
    i2s_sck  = 1'b1;
    rise_cyc = cyc;
    repeat (2) @(negedge clk);
    if (clr) clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    @(negedge clk);
  endtask

  // Word for channel c, MSB first; its LSB is sent after WS has flipped.
  task automatic send_word(input logic c, input logic [31:0] val, input int nbits,
                           input logic clr_last);
    logic [31:0] v;
    v = val << (32 - nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i == nbits - 1) ? ~c : c, v[31], clr_last && (i == nbits - 1));
      v = v << 1;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i2s_sck = ~i2s_sck;
      checks++;
      if ({wr_en, din, synced, overrun} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs got wr_en=%b din=%h synced=%b overrun=%b want all 0",
                 wr_en, din, synced, overrun);
      end
    end
    rst = 1'b0;
    i2s_sck = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (synced !== 1'b0 || q_din.size() != 0) begin
      errors++;
      $display("FAIL reset_idle got synced=%b pushes=%0d want 0/0", synced, q_din.size());
    end
  endtask

  task automatic test_basic;
    int chg;
    send_word(1'b1, 32'hFFFF, 16, 1'b0);
    checks++;
    if (synced !== 1'b1 || q_din.size() != 0) begin
      errors++;
      $display("FAIL basic_sync got synced=%b pushes=%0d want 1/0", synced, q_din.size());
    end
    send_word(1'b0, 32'hA5C3, 16, 1'b0);
    chg = rise_cyc;
    checks++;
    if (q_din.size() != 1) begin
      errors++;
      $display("FAIL basic_left_count got %0d want 1", q_din.size());
    end else begin
      checks++;
      if (q_din[0] !== 16'hA5C3 || q_ch[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_left got din=%h ch=%b want a5c3/0", q_din[0], q_ch[0]);
      end
      // Strobe lands in the (sync_stages+2)th clk period counted from the SCK pin edge
      checks++;
      if (q_cyc[0] != chg + 3) begin
        errors++;
        $display("FAIL basic_latency got %0d want %0d", q_cyc[0] - chg, 3);
      end
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
    send_word(1'b1, 32'h1234, 16, 1'b0);
    chg = rise_cyc;
    checks++;
    if (q_din.size() != 1) begin
      errors++;
      $display("FAIL basic_right_count got %0d want 1", q_din.size());
    end else begin
      checks++;
      if (q_din[0] !== 16'h1234 || q_ch[0] !== 1'b1 || q_cyc[0] != chg + 3) begin
        errors++;
        $display("FAIL basic_right got din=%h ch=%b lat=%0d want 1234/1/3",
                 q_din[0], q_ch[0], q_cyc[0] - chg);
      end
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
    repeat (10) @(negedge clk);
    checks++;
    if (din !== 16'h1234 || ch !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold got din=%h ch=%b wr_en=%b want 1234/1/0", din, ch, wr_en);
    end
  endtask

  task automatic test_slot_len;
    send_word(1'b0, 32'hDEADBEEF, 32, 1'b0);
    send_word(1'b1, 32'h000000AB, 8, 1'b0);
    checks++;
    if (q_din.size() != 2) begin
      errors++;
      $display("FAIL slot_count got %0d want 2", q_din.size());
    end else begin
      checks++;
      if (q_din[0] !== 16'hDEAD || q_ch[0] !== 1'b0) begin
        errors++;
        $display("FAIL slot_long got din=%h ch=%b want dead/0", q_din[0], q_ch[0]);
      end
      checks++;
      if (q_din[1] !== 16'hAB00 || q_ch[1] !== 1'b1) begin
        errors++;
        $display("FAIL slot_short got din=%h ch=%b want ab00/1", q_din[1], q_ch[1]);
      end
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
  endtask

  task automatic test_overrun;
    fifo_full = 1'b1;
    send_word(1'b0, 32'h1111, 16, 1'b0);
    fifo_full = 1'b0;
    checks++;
    if (q_din.size() != 0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop got pushes=%0d overrun=%b want 0/1", q_din.size(), overrun);
    end
    send_word(1'b1, 32'h2222, 16, 1'b0);
    checks++;
    if (q_din.size() != 1 || q_din[0] !== 16'h2222 || q_ch[0] !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_resume got pushes=%0d overrun=%b want 1 push of 2222/1 overrun 1",
               q_din.size(), overrun);
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b want 0", overrun);
    end
    fifo_full = 1'b1;
    send_word(1'b0, 32'h3333, 16, 1'b1);
    fifo_full = 1'b0;
    checks++;
    if (overrun !== 1'b1 || q_din.size() != 0) begin
      errors++;
      $display("FAIL ovr_clr_vs_drop got overrun=%b pushes=%0d want 1/0", overrun, q_din.size());
    end
    send_word(1'b1, 32'h4444, 16, 1'b0);
    checks++;
    if (q_din.size() != 1 || q_din[0] !== 16'h4444 || q_ch[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after got pushes=%0d want 1 push of 4444/1", q_din.size());
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || synced !== 1'b0 || overrun !== 1'b0 || din !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_clear got wr_en=%b synced=%b overrun=%b din=%h want 0",
               wr_en, synced, overrun, din);
    end
    rst = 1'b0;
    send_word(1'b0, 32'h5A5A, 16, 1'b0);
    checks++;
    if (synced !== 1'b1 || q_din.size() != 0) begin
      errors++;
      $display("FAIL rstmid_sync got synced=%b pushes=%0d want 1/0", synced, q_din.size());
    end
    send_word(1'b1, 32'hC001, 16, 1'b0);
    checks++;
    if (q_din.size() != 1 || q_din[0] !== 16'hC001 || q_ch[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_word got pushes=%0d want 1 push of c001/1", q_din.size());
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
  endtask

  task automatic test_enable;
    en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send_word(1'b0, 32'h9999, 16, 1'b0);
      send_word(1'b1, 32'h6666, 16, 1'b0);
      checks++;
      if (synced !== 1'b0 || q_din.size() != 0) begin
        errors++;
        $display("FAIL en_off got synced=%b pushes=%0d want 0/0", synced, q_din.size());
      end
    end
    en = 1'b1;
    send_word(1'b0, 32'h7777, 16, 1'b0);
    checks++;
    if (synced !== 1'b1 || q_din.size() != 0) begin
      errors++;
      $display("FAIL en_resync got synced=%b pushes=%0d want 1/0", synced, q_din.size());
    end
    send_word(1'b1, 32'hBEEF, 16, 1'b0);
    send_word(1'b0, 32'h0F0F, 16, 1'b0);
    checks++;
    if (q_din.size() != 2) begin
      errors++;
      $display("FAIL en_count got %0d want 2", q_din.size());
    end else begin
      checks++;
      if (q_din[0] !== 16'hBEEF || q_ch[0] !== 1'b1 || q_din[1] !== 16'h0F0F || q_ch[1] !== 1'b0) begin
        errors++;
        $display("FAIL en_words got %h/%b %h/%b want beef/1 0f0f/0",
                 q_din[0], q_ch[0], q_din[1], q_ch[1]);
      end
    end
    q_din.delete(); q_ch.delete(); q_cyc.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_slot_len();
    test_overrun();
    test_reset_mid();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Single-clock I2S slave receiver that oversamples external SCK/WS/SD and deserialises left/right audio words.
- Pushes each completed word into the write port of the IIS async FIFO: wr_en/din connect directly, and fifo_full comes from the FIFO full flag.
- Sits directly upstream of the FIFO in the write-clock domain; clk is that domain's wr_clk.

Parameters:
- data_width, 16, width of captured word and of din; must equal the FIFO data_width.
- sync_stages, 2, flip-flop stages on each asynchronous I2S input (min 2).
- cnt_width, 6, width of the per-slot bit counter; saturates at 2^cnt_width-1.

Ports:
- clk  input  1  system/FIFO write clock; must be at least 8x the SCK frequency.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  receiver enable; low clears sync state and suppresses output.
- clr_ovr  input  1  one-cycle pulse that clears the overrun flag.
- i2s_sck  input  1  I2S bit clock (async).
- i2s_ws  input  1  I2S word select (async); 0 = left, 1 = right.
- i2s_sd  input  1  I2S serial data (async), MSB first.
- fifo_full  input  1  FIFO full flag.
- wr_en  output  1  one-cycle write strobe to the FIFO.
- din  output  data_width  captured word to the FIFO.
- ch  output  1  channel of the word on din (0 left, 1 right); valid with wr_en.
- synced  output  1  frame alignment established.
- overrun  output  1  sticky: a completed word was dropped because fifo_full was high.

Behaviour:
- Reset (async, rst=1): wr_en=0, din=0, ch=0, synced=0, overrun=0. Synchroniser chains, shift register and bit counter all clear.
- Input conditioning: sck, ws and sd each pass through sync_stages flip-flops (sck_s, ws_s, sd_s). sck_d is sck_s delayed by one clk.
  - rise = sck_s & ~sck_d. All protocol actions occur only in rise cycles.
- Per rise cycle (en=1), with ws_p = ws_s value captured at the previous rise:
  - Normal bit (ws_s == ws_p): if bit_cnt < data_width, shreg[data_width-1-bit_cnt] <= sd_s. bit_cnt increments, saturating.
  - WS-change bit (ws_s != ws_p): this bit is the LSB of the word belonging to channel ws_p.
    - Insert the bit as above if bit_cnt < data_width.
    - The word is complete. Then clear shreg and set bit_cnt=0.
    - If synced=0: discard the word and set synced=1.
    - If synced=1: issue a push request.
  - ws_p <= ws_s on every rise cycle.
- Slot length rules:
  - Slots longer than data_width bits: the extra LSBs are ignored (truncation).
  - Slots shorter than data_width bits: unfilled LSBs are 0 (left-justified).
- Push: in the clk after the WS-change rise cycle, wr_en=1 for exactly one cycle, with din = completed word and ch = ws_p.
  - Latency from the SCK rising edge at the pin is sync_stages+2 clk cycles.
  - If fifo_full=1 in the WS-change rise cycle: wr_en stays 0, the word is dropped, and overrun is set.
- din and ch hold their last pushed value between pushes.
- overrun is sticky. clr_ovr=1 clears it; a drop in the same cycle as clr_ovr wins (overrun stays 1).
- en=0: no shifting, no pushes. synced<=0, bit_cnt<=0, shreg<=0; overrun holds.
  - On re-enable, ws_p is loaded from the first rise seen, and the first partial slot is discarded.
- Reset mid-word: everything clears; the first slot boundary after reset only establishes sync, so no partial word ever reaches the FIFO.
- No push is ever issued while synced=0.

Test Plan:
- Reset/idle: assert rst for 3 clk with SCK toggling -> wr_en=0, din=0, synced=0, overrun=0 throughout reset.
- Basic stereo, data_width=16, SCK=clk/8, 16-bit slots:
  - Stimulus: first slot garbage, then L=0xA5C3, R=0x1234.
  - Required: synced rises at the first WS edge, and the garbage slot produces no push.
  - Required: wr_en pulses with din=0xA5C3/ch=0, then din=0x1234/ch=1, each sync_stages+2 clk after the corresponding WS-change SCK rise.
- Slot-length rules:
  - 32-bit slot carrying 0xDEADBEEF -> din=0xDEAD.
  - 8-bit slot carrying 0xAB -> din=0xAB00.
- Overrun:
  - Hold fifo_full=1 across one WS edge -> no wr_en pulse, overrun=1; the following word pushes normally once fifo_full=0.
  - Pulse clr_ovr -> overrun=0.
  - clr_ovr coinciding with a drop -> overrun stays 1.
- Reset mid-frame: assert rst in the middle of a left word, release -> the next WS edge gives synced=1 with no push; the subsequent full word pushes correctly.
- Enable gating: drop en for 2 frames -> no wr_en and synced=0; re-raise en -> one slot discarded, then correct L/R words resume.
